// File: rtl/pc_predict_unit_pkg.sv
// rtl/pc_predict_unit_pkg.sv - shared icode constants and width defaults for the PC predictor
// Purpose: Y86-64 instruction codes and the default address width, shared by the
//          predictor, its return-address stack, its interface and the bench.
// Ports:   none (package).
package pc_predict_unit_pkg;

  localparam int ADDR_W_DEFAULT = 64;

  typedef enum logic [3:0] {
    IHALT   = 4'h0,
    INOP    = 4'h1,
    IRRMOVQ = 4'h2,
    IIRMOVQ = 4'h3,
    IRMMOVQ = 4'h4,
    IMRMOVQ = 4'h5,
    IOPQ    = 4'h6,
    IJXX    = 4'h7,
    ICALL   = 4'h8,
    IRET    = 4'h9,
    IPUSHQ  = 4'hA,
    IPOPQ   = 4'hB
  } icode_e;

endpackage

// File: rtl/pc_predict_unit_if.sv
// rtl/pc_predict_unit_if.sv - fetch/correction bus between pipeline control and the PC predictor
// Purpose: bundles the fetch-side inputs, M/W correction inputs and the predictor outputs.
// Ports:   slave  - the predictor: takes stall/icode/valC/valP/corrections, drives pc/pred_pc/ras_hit/halted.
//          master - pipeline side: the mirror image.
interface pc_predict_unit_if #(
  parameter int ADDR_W = 64
);
  logic              stall_i;
  logic [3:0]        icode_i;
  logic [ADDR_W-1:0] valC_i;
  logic [ADDR_W-1:0] valP_i;
  logic              m_mispred_i;
  logic [ADDR_W-1:0] m_valA_i;
  logic              w_ret_i;
  logic [ADDR_W-1:0] w_valM_i;
  logic [ADDR_W-1:0] pc_o;
  logic [ADDR_W-1:0] pred_pc_o;
  logic              ras_hit_o;
  logic              halted_o;

  modport slave (
    input  stall_i, icode_i, valC_i, valP_i, m_mispred_i, m_valA_i, w_ret_i, w_valM_i,
    output pc_o, pred_pc_o, ras_hit_o, halted_o
  );

  modport master (
    output stall_i, icode_i, valC_i, valP_i, m_mispred_i, m_valA_i, w_ret_i, w_valM_i,
    input  pc_o, pred_pc_o, ras_hit_o, halted_o
  );
endinterface

// File: rtl/pc_predict_unit_ras_stack.sv
// rtl/pc_predict_unit_ras_stack.sv - circular return-address stack
// Purpose: predicts ret targets. Push on call, pop on ret; overflow overwrites the
//          oldest entry, pop on empty is ignored.
// Ports:   clk_i, rst_i (sync active-high) | push, push_data | pop |
//          top_data (entry at top pointer), not_empty (count > 0).
module ras_stack #(
  parameter int ADDR_W    = 64,
  parameter int RAS_DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] top_data,
  output logic              not_empty
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  top_q;
  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  wr_ptr;

  // top_q addresses the most recent entry, so a push writes one slot above it.
  // Pointer arithmetic wraps naturally because RAS_DEPTH is a power of two.
  assign wr_ptr    = top_q + 1'b1;
  assign top_data  = mem[top_q];
  assign not_empty = (count_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      top_q   <= '0;
      count_q <= '0;
    end else if (push) begin
      top_q <= wr_ptr;
      if (count_q != CNT_W'(RAS_DEPTH)) count_q <= count_q + 1'b1;
    end else if (pop && not_empty) begin
      top_q   <= top_q - 1'b1;
      count_q <= count_q - 1'b1;
    end
  end

  // Entry contents carry no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/pc_predict_unit.sv
// rtl/pc_predict_unit.sv - fetch PC select, next-PC prediction and halt tracking
// Purpose: holds the predicted-PC register, picks the fetch PC (M mispredict, then
//          W ret, then prediction) and predicts the next PC using a RAS for rets.
// Ports:   clk_i, rst_i (sync active-high) | bus (pc_predict_unit_if.slave):
//          stall/icode/valC/valP/m_mispred/m_valA/w_ret/w_valM in,
//          pc_o/pred_pc_o/ras_hit_o/halted_o out.
module pc_predict_unit
  import pc_predict_unit_pkg::*;
#(
  parameter int              ADDR_W    = ADDR_W_DEFAULT,
  parameter int              RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  pc_predict_unit_if.slave   bus
);
  logic [ADDR_W-1:0] pred_pc_q;
  logic              halted_q;
  logic [ADDR_W-1:0] pc_sel;
  logic [ADDR_W-1:0] pred_next;
  logic              ras_hit;
  logic              correct;
  logic              update;
  logic              ras_push;
  logic              ras_pop;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_valid;

  // A correction must land even under stall, but a halt freezes everything until reset.
  assign correct = bus.m_mispred_i | bus.w_ret_i;
  assign update  = !halted_q && (!bus.stall_i || correct);

  // On a correction cycle the icode belongs to a squashed path, so it must not touch the RAS.
  assign ras_push = update && !correct && (bus.icode_i == ICALL);
  assign ras_pop  = update && !correct && (bus.icode_i == IRET);

  always_comb begin
    pc_sel = pred_pc_q;
    if (bus.m_mispred_i)  pc_sel = bus.m_valA_i;
    else if (bus.w_ret_i) pc_sel = bus.w_valM_i;
  end

  always_comb begin
    pred_next = bus.valP_i;
    ras_hit   = 1'b0;
    case (bus.icode_i)
      IJXX, ICALL: pred_next = bus.valC_i;
      IRET: begin
        if (ras_valid) begin
          pred_next = ras_top;
          ras_hit   = 1'b1;
        end
      end
      IHALT:   pred_next = pc_sel;
      default: pred_next = bus.valP_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pred_pc_q <= RESET_PC;
      halted_q  <= 1'b0;
    end else if (update) begin
      pred_pc_q <= pred_next;
      if (!correct && (bus.icode_i == IHALT)) halted_q <= 1'b1;
    end
  end

  ras_stack #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (ras_push),
    .push_data(bus.valP_i),
    .pop      (ras_pop),
    .top_data (ras_top),
    .not_empty(ras_valid)
  );

  assign bus.pc_o      = pc_sel;
  assign bus.pred_pc_o = pred_pc_q;
  assign bus.ras_hit_o = ras_hit;
  assign bus.halted_o  = halted_q;
endmodule

// File: tb/tb_pc_predict_unit.sv
// tb/tb_pc_predict_unit.sv - scoreboard bench for pc_predict_unit
module tb_pc_predict_unit;
  import pc_predict_unit_pkg::*;

  typedef struct {
    string       tag;
    logic [63:0] pc;
    logic [63:0] pred;
    logic        hit;
    logic        halt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  pc_predict_unit_if #(.ADDR_W(64)) bus ();

  pc_predict_unit #(
    .ADDR_W   (64),
    .RAS_DEPTH(4),
    .RESET_PC (64'h100)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one fetch cycle, queue what the outputs must be, then pop and compare before the edge.
  task automatic cyc(input string tag, input logic [3:0] ic, input logic [63:0] c,
                     input logic [63:0] p, input logic [63:0] e_pc, input logic [63:0] e_pred,
                     input logic e_hit, input logic e_halt,
                     input logic st = 1'b0, input logic ms = 1'b0, input logic [63:0] a = 64'h0,
                     input logic wr = 1'b0, input logic [63:0] m = 64'h0, input logic rs = 1'b0);
    exp_t e;
    exp_t o;
    @(negedge clk);
    rst             = rs;
    bus.icode_i     = ic;
    bus.valC_i      = c;
    bus.valP_i      = p;
    bus.stall_i     = st;
    bus.m_mispred_i = ms;
    bus.m_valA_i    = a;
    bus.w_ret_i     = wr;
    bus.w_valM_i    = m;
    e.tag = tag; e.pc = e_pc; e.pred = e_pred; e.hit = e_hit; e.halt = e_halt;
    sb.push_back(e);
    #1;
    o = sb.pop_front();
    check({o.tag, ".pc"},     bus.pc_o,               o.pc);
    check({o.tag, ".pred"},   bus.pred_pc_o,          o.pred);
    check({o.tag, ".hit"},    64'(bus.ras_hit_o),     64'(o.hit));
    check({o.tag, ".halted"}, 64'(bus.halted_o),      64'(o.halt));
  endtask

  initial begin
    logic [63:0] rp;
    bus.icode_i = INOP; bus.valC_i = '0; bus.valP_i = '0; bus.stall_i = 1'b0;
    bus.m_mispred_i = 1'b0; bus.m_valA_i = '0; bus.w_ret_i = 1'b0; bus.w_valM_i = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    cyc("rst_nop",  INOP,  64'h0,   64'h101, 64'h100, 64'h100, 1'b0, 1'b0);
    cyc("call",     ICALL, 64'h400, 64'h20A, 64'h101, 64'h101, 1'b0, 1'b0);
    cyc("ret_hit",  IRET,  64'h0,   64'h401, 64'h400, 64'h400, 1'b1, 1'b0);
    cyc("ret_empty",IRET,  64'h0,   64'h20B, 64'h20A, 64'h20A, 1'b0, 1'b0);
    cyc("jxx",      IJXX,  64'h300, 64'h214, 64'h20B, 64'h20B, 1'b0, 1'b0);
    cyc("jxx_tgt",  INOP,  64'h0,   64'h301, 64'h300, 64'h300, 1'b0, 1'b0);
    cyc("mispred",  ICALL, 64'h999, 64'h30A, 64'h113, 64'h301, 1'b0, 1'b0,
        1'b0, 1'b1, 64'h113);
    cyc("no_push",  IRET,  64'h0,   64'h99A, 64'h999, 64'h999, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      rp = (i == 0) ? 64'h99A : 64'hA00 + 64'(16 * (i - 1));
      cyc("call_ovf", ICALL, 64'hA00 + 64'(16 * i), 64'(16 * (i + 1)), rp, rp, 1'b0, 1'b0);
    end
    for (int j = 0; j < 5; j++) begin
      rp = (j == 0) ? 64'hA40 : 64'(16 * (6 - j));
      cyc("ret_ovf", IRET, 64'h0, 64'hB00 + 64'(j), rp, rp, (j < 4), 1'b0);
    end

    cyc("stall1",     INOP, 64'h0, 64'hB05, 64'hB04, 64'hB04, 1'b0, 1'b0, 1'b1);
    cyc("stall_wret", INOP, 64'h0, 64'h778, 64'h777, 64'hB04, 1'b0, 1'b0,
        1'b1, 1'b0, 64'h0, 1'b1, 64'h777);
    cyc("stall3",     INOP, 64'h0, 64'h779, 64'h778, 64'h778, 1'b0, 1'b0, 1'b1);
    cyc("unstall",    IJXX, 64'h50, 64'h77A, 64'h778, 64'h778, 1'b0, 1'b0);
    cyc("halt",       IHALT, 64'h0, 64'h51, 64'h50, 64'h50, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      cyc("halted",   INOP, 64'h0, 64'h51, 64'h50, 64'h50, 1'b0, 1'b1);
    cyc("rst_halt",   INOP, 64'h0, 64'h51, 64'h50, 64'h50, 1'b0, 1'b1,
        1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
    cyc("post_rst",   INOP, 64'h0, 64'h101, 64'h100, 64'h100, 1'b0, 1'b0);

    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
